// File: rtl/shift_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shift_ctrl_pkg
//   Shared types and constants for the shift-register exchange controller.
//   - SHIFT_CTRL_WIDTH : default bits per transfer
//   - state_e          : controller FSM state encoding (binary)
// ---------------------------------------------------------------------------
package shift_ctrl_pkg;

   localparam int SHIFT_CTRL_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/shift_ctrl.sv
// ---------------------------------------------------------------------------
// shift_ctrl
//   Exchanges one WIDTH-bit word with an external serial shift register.
//   The accepted word is shifted in LSB first while the old register
//   contents are sampled from the register's bit 0 and returned on rx_data.
//
//   Build option: define SHIFT_CTRL_B2B_EN to accept a new word in the DONE
//   cycle, giving back-to-back transfers every WIDTH+1 cycles. By default
//   DONE always returns to IDLE (minimum period WIDTH+2).
//
//   Ports:
//     CLK, Reset           clock, synchronous active-high reset
//     tx_valid/tx_data     requester word to exchange
//     tx_ready             word accepted this cycle when tx_valid is high
//     shift_en             shift-register enable
//     shift_in_o           serial bit into the register (0 when idle)
//     shift_out_i          register serial output (bit 0)
//     rx_valid             one-cycle pulse, rx_data holds the old contents
//     rx_data              previous register contents, held until next DONE
//     busy                 controller not in IDLE
// ---------------------------------------------------------------------------
module shift_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH = SHIFT_CTRL_WIDTH
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             tx_valid,
   input  logic [WIDTH-1:0] tx_data,
   output logic             tx_ready,
   output logic             shift_en,
   output logic             shift_in_o,
   input  logic             shift_out_i,
   output logic             rx_valid,
   output logic [WIDTH-1:0] rx_data,
   output logic             busy
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic             accept;

   // ---------------- FSM ----------------
   always_ff @(posedge CLK) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      tx_ready = 1'b0;
      shift_en = 1'b0;
      rx_valid = 1'b0;
      case (state_q)
         IDLE: begin
            // Ready is masked during reset so reset wins over tx_valid.
            tx_ready = ~Reset;
            if (tx_valid && tx_ready) state_d = SHIFT;
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (cnt_q == LAST) state_d = DONE;
         end
         DONE: begin
            rx_valid = 1'b1;
`ifdef SHIFT_CTRL_B2B_EN
            tx_ready = ~Reset;
            state_d  = (tx_valid && tx_ready) ? SHIFT : IDLE;
`else
            state_d  = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept     = tx_valid & tx_ready;
   assign busy       = (state_q != IDLE);
   assign shift_in_o = shift_en & data_q[cnt_q];
   assign rx_data    = rx_data_q;

   // ---------------- datapath ----------------
   always_comb begin
      data_d    = data_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      rx_data_d = rx_data_q;
      if (accept) begin
         data_d = tx_data;
         cnt_d  = '0;
      end else if (shift_en) begin
         acc_d[cnt_q] = shift_out_i;
         // Counter parks on the last index; publishing the completed word
         // here makes rx_data change exactly when rx_valid rises.
         if (cnt_q != LAST) cnt_d = cnt_q + CW'(1);
         else               rx_data_d = acc_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         data_q    <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         rx_data_q <= '0;
      end else begin
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         rx_data_q <= rx_data_d;
      end
   end

endmodule
